// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the SRAM-like CPU bus arbitration logic.
package cpu_bus_pkg;

  // Arbiter FSM encoding
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_ADDR = 2'd1,
    WAIT_DATA = 2'd2
  } state_t;

  // Requester identifiers
  localparam logic REQ_INST = 1'b0;
  localparam logic REQ_DATA = 1'b1;

  // Transfer size encodings
  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/arb2_pick.sv
// Two-way requester pick: fixed data-first priority or round-robin.
import cpu_bus_pkg::*;

module arb2_pick #(
  parameter int ARB_MODE = 0
) (
  input  logic inst_req,
  input  logic data_req,
  input  logic rr_last,
  output logic any_req,
  output logic winner
);

  // On a tie, round-robin hands the grant to whoever was not served last
  always_comb begin
    any_req = inst_req | data_req;
    winner  = REQ_INST;
    if (inst_req && data_req)
      winner = (ARB_MODE == 1) ? ~rr_last : REQ_DATA;
    else if (data_req)
      winner = REQ_DATA;
  end

endmodule

// File: rtl/sram_like_arb_2x1.sv
// Arbitrates inst/data SRAM-like streams onto one SRAM-like master port,
// one outstanding transaction at a time.
import cpu_bus_pkg::*;

module sram_like_arb_2x1 #(
  parameter int ARB_MODE = 0,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_req,
  input  logic              inst_wr,
  input  logic [1:0]        inst_size,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic [DATA_W-1:0] inst_wdata,
  output logic [DATA_W-1:0] inst_rdata,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic [DATA_W-1:0] data_rdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic              m_req,
  output logic              m_wr,
  output logic [1:0]        m_size,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_addr_ok,
  input  logic              m_data_ok
);

  state_t state;
  logic   owner;
  logic   rr_last;
  logic   any_req;
  logic   winner;
  logic   sel;
  logic   sel_req;

  arb2_pick #(.ARB_MODE(ARB_MODE)) u_pick (
    .inst_req (inst_req),
    .data_req (data_req),
    .rr_last  (rr_last),
    .any_req  (any_req),
    .winner   (winner)
  );

  // Fresh pick while idle; afterwards the owner is locked until the handshake ends
  assign sel     = (state == IDLE) ? winner : owner;
  assign sel_req = (sel == REQ_DATA) ? data_req : inst_req;

  // Request mux toward the master port and response demux back to the owner
  always_comb begin
    m_req        = 1'b0;
    m_wr         = 1'b0;
    m_size       = '0;
    m_addr       = '0;
    m_wdata      = '0;
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    data_data_ok = 1'b0;
    inst_rdata   = '0;
    data_rdata   = '0;
    // Everything stays quiet while reset is held
    if (rst) begin
      if (state != WAIT_DATA && sel_req) begin
        m_req = 1'b1;
        if (sel == REQ_DATA) begin
          m_wr         = data_wr;
          m_size       = data_size;
          m_addr       = data_addr;
          m_wdata      = data_wdata;
          data_addr_ok = m_addr_ok;
        end else begin
          m_wr         = inst_wr;
          m_size       = inst_size;
          m_addr       = inst_addr;
          m_wdata      = inst_wdata;
          inst_addr_ok = m_addr_ok;
        end
      end
      if (state == WAIT_DATA) begin
        inst_rdata = m_rdata;
        data_rdata = m_rdata;
        if (owner == REQ_DATA) data_data_ok = m_data_ok;
        else                   inst_data_ok = m_data_ok;
      end
    end
  end

  // Transaction FSM: grant, address handshake, then wait for the data response
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      owner   <= REQ_DATA;
      rr_last <= REQ_INST;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            owner <= winner;
            if (m_addr_ok) begin
              rr_last <= winner;
              state   <= WAIT_DATA;
            end else begin
              state   <= WAIT_ADDR;
            end
          end
        end
        WAIT_ADDR: begin
          // Owner withdrawing before acceptance abandons the transaction
          if (!sel_req) begin
            state <= IDLE;
          end else if (m_addr_ok) begin
            rr_last <= owner;
            state   <= WAIT_DATA;
          end
        end
        WAIT_DATA: begin
          if (m_data_ok) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/sram_like_arb_2x1.md
Name: sram_like_arb_2x1

Overview:
- Arbitrates the instruction-side and data-side SRAM-like miss/uncached streams onto a single SRAM-like master port toward the AXI conversion bridge.
- Allows one outstanding transaction at a time.
- Routes addr_ok, data_ok and rdata back to the requester that owns the current transaction.
- Sits between the cache layer (inst and data cache outputs) and the SRAM-to-AXI bridge.

Parameters:
- ARB_MODE, 0, 0 = fixed priority (data over inst); 1 = round-robin (last-served requester gets lower priority).
- ADDR_W, 32, address width.
- DATA_W, 32, data width.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- inst_req  in  1  inst requester: request valid.
- inst_wr  in  1  inst requester: write flag.
- inst_size  in  2  inst requester: size (0=byte, 1=half, 2=word).
- inst_addr  in  ADDR_W  inst requester: address.
- inst_wdata  in  DATA_W  inst requester: write data.
- inst_rdata  out  DATA_W  inst requester: read data.
- inst_addr_ok  out  1  inst requester: address accepted.
- inst_data_ok  out  1  inst requester: data done.
- data_req, data_wr, data_size, data_addr, data_wdata  in  same widths  data requester, same meaning as inst_*.
- data_rdata, data_addr_ok, data_data_ok  out  same widths  data requester, same meaning as inst_*.
- m_req  out  1  shared port: request valid.
- m_wr  out  1  shared port: write flag.
- m_size  out  2  shared port: size.
- m_addr  out  ADDR_W  shared port: address.
- m_wdata  out  DATA_W  shared port: write data.
- m_rdata  in  DATA_W  shared port: read data.
- m_addr_ok  in  1  shared port: address accepted.
- m_data_ok  in  1  shared port: data done.

Behaviour:
- Reset values:
  - state=IDLE, owner=DATA, rr_last=INST.
  - Every output is 0 during and after reset until a request arrives.
  - Reset mid-transaction drops the outstanding response; no data_ok is forwarded.
- State IDLE:
  - Winner is chosen combinationally from {inst_req, data_req}.
  - ARB_MODE=0: data wins when both are asserted.
  - ARB_MODE=1: the requester not equal to rr_last wins a tie; a single requester always wins.
  - The winner's wr/size/addr/wdata drive m_*; m_req=1.
  - The winner's *_addr_ok equals m_addr_ok; the loser's addr_ok is 0.
  - m_addr_ok=1: latch owner=winner, rr_last=winner, go to WAIT_DATA (zero-latency grant).
  - m_addr_ok=0: latch owner=winner, go to WAIT_ADDR.
- State WAIT_ADDR:
  - m_* is driven from the owner only; owner is locked so the request cannot switch mid-handshake.
  - Owner's addr_ok equals m_addr_ok.
  - On m_addr_ok go to WAIT_DATA and set rr_last=owner.
  - If the owner drops req without addr_ok (protocol violation), return to IDLE.
- State WAIT_DATA:
  - m_req=0.
  - m_rdata is passed combinationally to both *_rdata.
  - Only the owner's *_data_ok equals m_data_ok.
  - On m_data_ok go to IDLE; a new grant is possible the next cycle, giving a minimum of 2 cycles between grants.
- Handshake timing:
  - m_data_ok arriving in IDLE or WAIT_ADDR is ignored and never forwarded.
  - The downstream slave must not return data_ok in the same cycle as addr_ok for the same transaction.
- Non-owner requester:
  - Sees addr_ok=0 and data_ok=0 for the whole transaction.
  - Must hold its req/addr stable; it is served next when state returns to IDLE.
- Fairness:
  - ARB_MODE=1 guarantees neither side waits more than one foreign transaction.
  - ARB_MODE=0 may starve inst under continuous data traffic; this is the intended behaviour.
- No width conversion; all fields pass through unchanged.

Decomposition:
- Shared package cpu_bus_pkg holds:
  - state encoding IDLE/WAIT_ADDR/WAIT_DATA (2 bits);
  - requester ID constants REQ_INST=0, REQ_DATA=1;
  - SIZE_BYTE/HALF/WORD constants.
- One natural sub-module, arb2_pick: the combinational 2-way priority/round-robin pick from (inst_req, data_req, rr_last, ARB_MODE).
- The FSM and the mux remain in the top.

Test Plan:
- Fixed priority, simultaneous requests:
  - Stimulus: ARB_MODE=0; inst_req and data_req both asserted (inst addr 0xBFC00000, data addr 0x80001000 read); slave gives addr_ok at once and data_ok 3 cycles later with rdata 0xDEADBEEF.
  - Required: m_addr=0x80001000 first; data_data_ok=1 and data_rdata=0xDEADBEEF; the inst handshake starts the cycle after data_ok; inst_data_ok stays 0 throughout.
- Round-robin:
  - Stimulus: ARB_MODE=1; both requesters held for 4 transactions.
  - Required: grant order is data, inst, data, inst.
- Delayed addr_ok:
  - Stimulus: slave holds m_addr_ok=0 for 5 cycles; data_req is raised while inst is already pending in WAIT_ADDR.
  - Required: m_addr stays equal to inst_addr in every cycle; inst_addr_ok pulses exactly once.
- Write pass-through:
  - Stimulus: data write, size=0, addr 0x80000003, wdata 0x000000AB.
  - Required: m_wr=1, m_size=0, m_wdata=0x000000AB; data_data_ok pulses once.
- Spurious data_ok:
  - Stimulus: m_data_ok=1 pulse while in IDLE with no outstanding transaction.
  - Required: both *_data_ok stay 0; the state remains IDLE.
- Reset mid-transaction:
  - Stimulus: assert rst=0 while in WAIT_DATA, release, then the slave returns data_ok.
  - Required: no *_data_ok pulse; all outputs 0; the next request is granted normally.
